alu_ctrl_muldiv: RTL

Second-generation ALU control for the MIPS-style execute stage. It keeps the combinational funct/alu_op decode to the 4-bit ALU operation code and widens the funct table. It adds a parametrised iterative multiply/divide unit that owns the HI/LO registers, and it generates the pipeline stall for HI/LO hazards. It sits beside the main ALU in execute. Its md_result/md_sel outputs feed the execute result mux.

---
 rtl/alu_ctrl_muldiv.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_muldiv.sv
// ALU control for the execute stage: funct/alu_op decode to the 4-bit ALU
// operation, an iterative multiply/divide unit that owns HI/LO, and the
// HI/LO hazard stall. md_result/md_sel feed the execute result mux.
module alu_ctrl_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       op,
  output logic             illegal,
  output logic [WIDTH-1:0] md_result,
  output logic             md_sel,
  output logic             busy,
  output logic             stall
);

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t               state_q;
  logic                 busy_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     a_q;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   p_q;      // {acc/remainder, multiplier/quotient}
  logic                 sa_q;     // rs operand was negative (signed op)
  logic                 sb_q;     // rt operand was negative (signed op)
  logic                 div_q;
  logic                 divz_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic                 md_grp;
  logic                 accept;
  logic                 s_rs, s_rt;
  logic [WIDTH-1:0]     mag_rs, mag_rt;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_sh;
  logic [WIDTH+1:0]     div_diff;
  logic                 div_ok;
  logic [2*WIDTH-1:0]   div_next;
  logic [WIDTH-1:0]     fix_hi, fix_lo;
  logic [2*WIDTH-1:0]   fix_prod;

  // Combinational decode of alu_op/funct to the ALU op code and MD group.
  always_comb begin
    op      = 4'b0000;
    illegal = 1'b0;
    md_grp  = 1'b0;
    md_sel  = 1'b0;
    unique case (alu_op)
      2'b00: op = 4'b0010;
      2'b01: op = 4'b0110;
      2'b11: illegal = 1'b1;
      default: begin
        case (funct)
          F_SLL: op = 4'b1101;
          F_SRL: op = 4'b1110;
          F_SRA: op = 4'b1111;
          F_ADD: op = 4'b0010;
          F_SUB: op = 4'b0110;
          F_SLT: op = 4'b0111;
          F_AND: op = 4'b0000;
          F_OR:  op = 4'b0001;
          F_NOR: op = 4'b1100;
          F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO: begin
            op     = 4'b0010;
            md_grp = 1'b1;
          end
          F_MFHI, F_MFLO: begin
            op     = 4'b0010;
            md_grp = 1'b1;
            md_sel = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

  assign md_result = (funct == F_MFHI) ? hi_q : lo_q;
  assign busy      = busy_q;
  assign stall     = valid & busy_q & md_grp;
  assign accept    = valid & ~busy_q & (alu_op == 2'b10);

  // Operand magnitudes and signs; even funct codes are the signed variants.
  always_comb begin
    s_rs   = ~funct[0] & rs_val[WIDTH-1];
    s_rt   = ~funct[0] & rt_val[WIDTH-1];
    mag_rs = s_rs ? -rs_val : rs_val;
    mag_rt = s_rt ? -rt_val : rt_val;
  end

  // One shift-add multiply step and one restoring-divide step.
  always_comb begin
    mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, p_q[WIDTH-1:1]};
    div_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    div_diff = {1'b0, div_sh} - {2'b00, a_q};
    div_ok   = ~div_diff[WIDTH+1];
    div_next = {(div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                p_q[WIDTH-2:0], div_ok};
  end

  // Sign correction applied on the way out of FIX. With a zero divisor the
  // restoring loop leaves the dividend magnitude as remainder, so restoring
  // the dividend sign reproduces rs_val in HI for both signednesses.
  always_comb begin
    fix_prod = (sa_q ^ sb_q) ? -p_q : p_q;
    if (div_q) begin
      fix_hi = sa_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
      fix_lo = divz_q ? '1 : ((sa_q ^ sb_q) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0]);
    end else begin
      fix_hi = fix_prod[2*WIDTH-1:WIDTH];
      fix_lo = fix_prod[WIDTH-1:0];
    end
  end

  // Multiply/divide FSM with its datapath and the HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      p_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div_q   <= 1'b0;
      divz_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (funct)
              F_MTHI: hi_q <= rs_val;
              F_MTLO: lo_q <= rs_val;
              F_MULT, F_MULTU: begin
                state_q <= MUL;
                busy_q  <= 1'b1;
                cnt_q   <= CNT_W'(WIDTH);
                a_q     <= mag_rs;
                p_q     <= {{WIDTH{1'b0}}, mag_rt};
                sa_q    <= s_rs;
                sb_q    <= s_rt;
                div_q   <= 1'b0;
                divz_q  <= 1'b0;
              end
              F_DIV, F_DIVU: begin
                state_q <= DIV;
                busy_q  <= 1'b1;
                cnt_q   <= CNT_W'(WIDTH);
                a_q     <= mag_rt;
                p_q     <= {{WIDTH{1'b0}}, mag_rs};
                sa_q    <= s_rs;
                sb_q    <= s_rt;
                div_q   <= 1'b1;
                divz_q  <= (rt_val == '0);
              end
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          p_q   <= (state_q == MUL) ? mul_next : div_next;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
